// File: rtl/watch_pkg.sv
// Shared definitions for the watch set-mode control unit.
//   state_t        : set-mode FSM state encoding
//   FIELD_*        : field codes driven on o_field (display blink select)
//   *_CYC_DEF      : default cycle counts for a 100 MHz clock
//   field_of()     : state -> field code decode
//   next_mode()    : state sequence followed on each mode button press
package watch_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_SEC  = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_HOUR = 2'd3;

  localparam int HOLD_CYC_DEF    = 50_000_000;
  localparam int REPEAT_CYC_DEF  = 10_000_000;
  localparam int TIMEOUT_CYC_DEF = 1_000_000_000;

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      ST_SET_HOUR: field_of = FIELD_HOUR;
      ST_SET_MIN:  field_of = FIELD_MIN;
      ST_SET_SEC:  field_of = FIELD_SEC;
      default:     field_of = FIELD_NONE;
    endcase
  endfunction

  function automatic state_t next_mode(input state_t s);
    case (s)
      ST_RUN:      next_mode = ST_SET_HOUR;
      ST_SET_HOUR: next_mode = ST_SET_MIN;
      ST_SET_MIN:  next_mode = ST_SET_SEC;
      default:     next_mode = ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_repeat_gen.sv
// Up-button pulse generator: one pulse on a fresh rising edge, then
// auto-repeat while the button stays held.
//   clk, p_rst : clock, synchronous active-high reset
//   enable     : high while the FSM is in a set state
//   clear      : drop any press in progress (mode change / timeout)
//   level      : debounced button level
//   o_pulse    : registered one-cycle increment request
module btn_repeat_gen
  import watch_pkg::*;
#(
  parameter int HOLD_CYC   = HOLD_CYC_DEF,
  parameter int REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic clk,
  input  logic p_rst,
  input  logic enable,
  input  logic clear,
  input  logic level,
  output logic o_pulse
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int RW = $clog2(REPEAT_CYC + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);

  logic          level_q;
  // 'active' is set only by a rising edge seen while enabled, so a button
  // that was already held across a mode change or reset stays inert until
  // it is released and pressed again.
  logic          active;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;

  always_ff @(posedge clk) begin
    if (p_rst) begin
      level_q  <= 1'b0;
      active   <= 1'b0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      o_pulse  <= 1'b0;
    end else begin
      level_q <= level;
      o_pulse <= 1'b0;
      if (!enable || clear || !level) begin
        active   <= 1'b0;
        hold_cnt <= '0;
        rep_cnt  <= '0;
      end else if (!level_q) begin
        active   <= 1'b1;
        hold_cnt <= HW'(1);
        o_pulse  <= 1'b1;
      end else if (active) begin
        // Hold counter saturates at HOLD_CYC; from then on the repeat
        // counter cycles 0..REPEAT_CYC-1 and fires on each return to 0.
        if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + HW'(1);
        end else begin
          if (rep_cnt == '0) o_pulse <= 1'b1;
          rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + RW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/watch_set_cu.sv
// Watch set-mode control unit.
// Mode button steps RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN; the up
// button yields single-cycle increment pulses for the field being set,
// with auto-repeat while held.
//   clk, p_rst           : clock, synchronous active-high reset
//   i_btn_mode           : mode press, one-cycle pulse
//   i_btn_up             : up button level
//   o_inc_sec/min/hour   : one-cycle increment pulses to the datapath
//   o_field              : 0 none, 1 sec, 2 min, 3 hour
//   o_setting            : high in any set state
// Optional: define WATCH_SET_TIMEOUT_EN to leave set mode after
// TIMEOUT_CYC cycles without button activity.
module watch_set_cu
  import watch_pkg::*;
#(
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int REPEAT_CYC  = REPEAT_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       p_rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  output logic       o_inc_sec,
  output logic       o_inc_min,
  output logic       o_inc_hour,
  output logic [1:0] o_field,
  output logic       o_setting
);

  state_t state_q;
  state_t state_d;
  logic   tmo_hit;
  logic   rep_clear;
  logic   rep_enable;
  logic   up_pulse;

`ifdef WATCH_SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_cnt;

  always_comb begin
    tmo_hit = (state_q != ST_RUN) && !i_btn_mode && !i_btn_up &&
              (tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge clk) begin
    if (p_rst) begin
      tmo_cnt <= '0;
    end else if (state_q == ST_RUN || i_btn_mode || i_btn_up || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  // Timeout parameter has no effect in this build.
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYC == 0);
  assign tmo_hit    = 1'b0;
`endif

  // Mode press takes priority over the timeout and over any up-button edge.
  always_comb begin
    state_d = state_q;
    if (i_btn_mode)   state_d = next_mode(state_q);
    else if (tmo_hit) state_d = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (p_rst) begin
      state_q   <= ST_RUN;
      o_field   <= FIELD_NONE;
      o_setting <= 1'b0;
    end else begin
      state_q   <= state_d;
      o_field   <= field_of(state_d);
      o_setting <= (state_d != ST_RUN);
    end
  end

  assign rep_enable = (state_q != ST_RUN);
  assign rep_clear  = i_btn_mode | tmo_hit;

  btn_repeat_gen #(
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_rep (
    .clk     (clk),
    .p_rst   (p_rst),
    .enable  (rep_enable),
    .clear   (rep_clear),
    .level   (i_btn_up),
    .o_pulse (up_pulse)
  );

  // The pulse register and o_field both reflect the state at the cycle the
  // pulse was decided; a state change in that cycle already cleared it.
  assign o_inc_hour = up_pulse & (o_field == FIELD_HOUR);
  assign o_inc_min  = up_pulse & (o_field == FIELD_MIN);
  assign o_inc_sec  = up_pulse & (o_field == FIELD_SEC);

endmodule

// File: tb/tb_watch_set_cu.sv
module tb_watch_set_cu;

  localparam int HOLD    = 10;
  localparam int REPEAT  = 4;
  localparam int TIMEOUT = 50;

  logic       clk = 1'b0;
  logic       p_rst;
  logic       i_btn_mode;
  logic       i_btn_up;
  logic       o_inc_sec;
  logic       o_inc_min;
  logic       o_inc_hour;
  logic [1:0] o_field;
  logic       o_setting;

  int n_chk  = 0;
  int n_fail = 0;

  watch_set_cu #(
    .HOLD_CYC    (HOLD),
    .REPEAT_CYC  (REPEAT),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk        (clk),
    .p_rst      (p_rst),
    .i_btn_mode (i_btn_mode),
    .i_btn_up   (i_btn_up),
    .o_inc_sec  (o_inc_sec),
    .o_inc_min  (o_inc_min),
    .o_inc_hour (o_inc_hour),
    .o_field    (o_field),
    .o_setting  (o_setting)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Inputs change #1 after an edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_incs(input string tag, input logic h, input logic m, input logic s);
    check({tag, ".hour"}, {31'd0, o_inc_hour}, {31'd0, h});
    check({tag, ".min"},  {31'd0, o_inc_min},  {31'd0, m});
    check({tag, ".sec"},  {31'd0, o_inc_sec},  {31'd0, s});
  endtask

  task automatic check_state(input string tag, input logic [1:0] f, input logic s);
    check({tag, ".field"},   {30'd0, o_field},   {30'd0, f});
    check({tag, ".setting"}, {31'd0, o_setting}, {31'd0, s});
  endtask

  task automatic mode_press();
    i_btn_mode = 1'b1;
    tick();
    i_btn_mode = 1'b0;
  endtask

  initial begin
    logic exp_s;
    p_rst = 1'b1; i_btn_mode = 1'b0; i_btn_up = 1'b0;
    tick(); tick();
    p_rst = 1'b0;
    check_state("reset", 2'd0, 1'b0);
    check_incs("reset", 1'b0, 1'b0, 1'b0);

    // Up ignored in RUN
    i_btn_up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_incs("run_up", 1'b0, 1'b0, 1'b0);
      check_state("run_up", 2'd0, 1'b0);
    end
    i_btn_up = 1'b0;
    tick();

    // SET_HOUR: single press, two cycles high
    mode_press();
    check_state("set_hour", 2'd3, 1'b1);
    check_incs("set_hour_idle", 1'b0, 1'b0, 1'b0);
    i_btn_up = 1'b1;
    tick();
    check_incs("hour_edge", 1'b1, 1'b0, 1'b0);
    tick();
    check_incs("hour_after", 1'b0, 1'b0, 1'b0);
    i_btn_up = 1'b0;
    tick();
    check_incs("hour_rel", 1'b0, 1'b0, 1'b0);

    // Two more presses -> SET_SEC, hold 20 cycles
    mode_press();
    check_state("set_min", 2'd2, 1'b1);
    tick();
    mode_press();
    check_state("set_sec", 2'd1, 1'b1);
    i_btn_up = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      exp_s = (n == 1 || n == 11 || n == 15 || n == 19);
      check_incs($sformatf("sec_hold%0d", n), 1'b0, 1'b0, exp_s);
    end
    i_btn_up = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      check_incs($sformatf("sec_rel%0d", n), 1'b0, 1'b0, 1'b0);
    end

    // SET_SEC -> RUN -> SET_HOUR -> SET_MIN
    mode_press(); mode_press(); mode_press();
    check_state("to_min", 2'd2, 1'b1);
    i_btn_up = 1'b1;
    tick();
    check_incs("min_edge", 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) tick();
    // Mode while held: moves to SET_SEC, held button stays inert
    i_btn_mode = 1'b1;
    tick();
    i_btn_mode = 1'b0;
    check_state("held_mode", 2'd1, 1'b1);
    check_incs("held_mode", 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 15; n++) begin
      tick();
      check_incs($sformatf("held_blk%0d", n), 1'b0, 1'b0, 1'b0);
    end
    i_btn_up = 1'b0;
    tick();
    i_btn_up = 1'b1;
    tick();
    check_incs("repress", 1'b0, 1'b0, 1'b1);
    tick();
    check_incs("repress_after", 1'b0, 1'b0, 1'b0);
    i_btn_up = 1'b0;
    tick();

    // Mode and up edge together in SET_SEC -> RUN, no pulse
    i_btn_mode = 1'b1; i_btn_up = 1'b1;
    tick();
    i_btn_mode = 1'b0;
    check_state("mode_up", 2'd0, 1'b0);
    check_incs("mode_up", 1'b0, 1'b0, 1'b0);
    tick();
    check_incs("mode_up_next", 1'b0, 1'b0, 1'b0);
    i_btn_up = 1'b0;
    tick();

    // Reset mid-hold in SET_HOUR
    mode_press();
    check_state("rst_sethour", 2'd3, 1'b1);
    i_btn_up = 1'b1;
    tick();
    check_incs("rst_edge", 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) tick();
    p_rst = 1'b1;
    tick();
    p_rst = 1'b0;
    check_state("rst_mid", 2'd0, 1'b0);
    check_incs("rst_mid", 1'b0, 1'b0, 1'b0);
    // Still held after reset: entering SET_HOUR yields nothing
    mode_press();
    check_state("rst_reenter", 2'd3, 1'b1);
    for (int n = 0; n < 14; n++) begin
      tick();
      check_incs($sformatf("rst_blk%0d", n), 1'b0, 1'b0, 1'b0);
    end
    i_btn_up = 1'b0;
    tick();
    i_btn_up = 1'b1;
    tick();
    check_incs("rst_repress", 1'b1, 1'b0, 1'b0);
    i_btn_up = 1'b0;
    tick();

    // Inactivity behaviour from a fresh SET_HOUR entry
    p_rst = 1'b1;
    tick();
    p_rst = 1'b0;
    mode_press();
    check_state("tmo_enter", 2'd3, 1'b1);
`ifdef WATCH_SET_TIMEOUT_EN
    for (int n = 0; n < TIMEOUT - 1; n++) tick();
    check_state("tmo_before", 2'd3, 1'b1);
    tick();
    check_state("tmo_after", 2'd0, 1'b0);
`else
    for (int n = 0; n < 200; n++) tick();
    check_state("no_tmo", 2'd3, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
